// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: control sequencer for the LC-3 operate instructions
// (ADD, AND, NOT). Accepts one instruction per handshake, drives register-file
// addresses and ALU controls, strobes writeback and owns the N/Z/P codes.
module alu_op_sequencer #(
    parameter bit STRICT_NOT = 1'b1,
    parameter bit SET_CC     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2,
    output logic [1:0]  aluk,
    output logic [5:0]  alu_ir_slice,
    output logic        gate_alu,
    input  logic [15:0] bus,
    output logic        ld_reg,
    output logic [2:0]  dr,
    output logic        ld_cc,
    output logic [2:0]  nzp,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;       // opcode of the captured word
    logic [5:0]  lo6_q, lo6_d;     // raw ir[5:0], needed for NOT legality
    logic [2:0]  sr1_q, sr1_d;
    logic [2:0]  sr2_q, sr2_d;
    logic [2:0]  dr_q, dr_d;
    logic [1:0]  aluk_q, aluk_d;
    logic [5:0]  slice_q, slice_d;
    logic [2:0]  nzp_q, nzp_d;
    logic        legal;

    // Legality of the captured word, evaluated while in DECODE.
    always_comb begin
        legal = 1'b0;
        case (op_q)
            OP_ADD:  legal = 1'b1;
            OP_AND:  legal = 1'b1;
            OP_NOT:  legal = !(STRICT_NOT && (lo6_q != 6'b111111));
            default: legal = 1'b0;
        endcase
    end

    // Next-state logic: capture in IDLE, branch in DECODE, update codes in EXEC.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        lo6_d   = lo6_q;
        sr1_d   = sr1_q;
        sr2_d   = sr2_q;
        dr_d    = dr_q;
        aluk_d  = aluk_q;
        slice_d = slice_q;
        nzp_d   = nzp_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    // Fields are registered at capture so they are already
                    // stable during DECODE and hold through DONE and after.
                    op_d    = instr[15:12];
                    lo6_d   = instr[5:0];
                    sr1_d   = instr[8:6];
                    sr2_d   = instr[2:0];
                    dr_d    = instr[11:9];
                    slice_d = (instr[15:12] == OP_NOT) ? 6'b0 : instr[5:0];
                    case (instr[15:12])
                        OP_AND:  aluk_d = 2'b01;
                        OP_NOT:  aluk_d = 2'b10;
                        default: aluk_d = 2'b00;
                    endcase
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = legal ? S_EXEC : S_IDLE;
            S_EXEC: begin
                if (SET_CC) begin
                    if (bus[15])           nzp_d = 3'b100;
                    else if (bus == 16'h0) nzp_d = 3'b010;
                    else                   nzp_d = 3'b001;
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 4'h0;
            lo6_q   <= 6'h0;
            sr1_q   <= 3'h0;
            sr2_q   <= 3'h0;
            dr_q    <= 3'h0;
            aluk_q  <= 2'b00;
            slice_q <= 6'h0;
            nzp_q   <= 3'b010;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            lo6_q   <= lo6_d;
            sr1_q   <= sr1_d;
            sr2_q   <= sr2_d;
            dr_q    <= dr_d;
            aluk_q  <= aluk_d;
            slice_q <= slice_d;
            nzp_q   <= nzp_d;
        end
    end

    // Strobes decode from state; rst masks them so an instruction caught by
    // reset mid-EXEC never reaches the register file.
    always_comb begin
        instr_ready  = (state_q == S_IDLE);
        busy         = (state_q != S_IDLE);
        gate_alu     = (state_q == S_EXEC) && !rst;
        ld_reg       = (state_q == S_EXEC) && !rst;
        ld_cc        = (state_q == S_EXEC) && !rst && SET_CC;
        done         = (state_q == S_DONE) && !rst;
        illegal      = (state_q == S_DECODE) && !legal && !rst;
        sr1          = sr1_q;
        sr2          = sr2_q;
        dr           = dr_q;
        aluk         = aluk_q;
        alu_ir_slice = slice_q;
        nzp          = nzp_q;
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a small register file and ALU surround the DUT,
// and an instruction-level reference model predicts results and codes.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [2:0]  sr1, sr2, dr, nzp;
    logic [1:0]  aluk;
    logic [5:0]  alu_ir_slice;
    logic        gate_alu, ld_reg, ld_cc, busy, done, illegal;
    logic [15:0] bus;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.STRICT_NOT(1'b1), .SET_CC(1'b1)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .sr1(sr1), .sr2(sr2), .aluk(aluk), .alu_ir_slice(alu_ir_slice),
        .gate_alu(gate_alu), .bus(bus), .ld_reg(ld_reg), .dr(dr), .ld_cc(ld_cc),
        .nzp(nzp), .busy(busy), .done(done), .illegal(illegal)
    );

    // Environment: register file and combinational ALU driving the bus.
    logic [15:0] env_regs [8];
    logic [15:0] ref_regs [8];
    logic [2:0]  ref_nzp;
    logic        pre_we;
    logic [2:0]  pre_a;
    logic [15:0] pre_d;
    logic [15:0] alu_b, alu_out;

    always_comb begin
        alu_b = alu_ir_slice[5] ? {{11{alu_ir_slice[4]}}, alu_ir_slice[4:0]} : env_regs[sr2];
        case (aluk)
            2'b00:   alu_out = env_regs[sr1] + alu_b;
            2'b01:   alu_out = env_regs[sr1] & alu_b;
            2'b10:   alu_out = ~env_regs[sr1];
            default: alu_out = env_regs[sr1];
        endcase
        bus = gate_alu ? alu_out : 16'h0000;
    end

    always @(posedge clk) begin
        if (ld_reg)      env_regs[dr]    <= bus;
        else if (pre_we) env_regs[pre_a] <= pre_d;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v[15])          return 3'b100;
        else if (v == 16'h0) return 3'b010;
        else                return 3'b001;
    endfunction

    // Called at a negedge while the DUT is idle.
    task automatic set_reg(input logic [2:0] a, input logic [15:0] v);
        pre_we = 1'b1; pre_a = a; pre_d = v;
        @(negedge clk);
        pre_we = 1'b0;
        ref_regs[a] = v;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) check(tag, env_regs[i], ref_regs[i]);
    endtask

    // Issue one word starting at a negedge in IDLE; returns at a negedge in IDLE.
    task automatic run(input logic [15:0] w, input bit hold);
        logic [3:0]  op;
        logic        legal;
        logic [15:0] a, b, res;
        logic [1:0]  exp_aluk;
        op    = w[15:12];
        legal = (op == 4'h1) || (op == 4'h5) || (op == 4'h9 && w[5:0] == 6'h3F);
        a     = ref_regs[w[8:6]];
        b     = w[5] ? {{11{w[4]}}, w[4:0]} : ref_regs[w[2:0]];
        res   = (op == 4'h1) ? a + b : (op == 4'h5) ? (a & b) : ~a;
        exp_aluk = (op == 4'h5) ? 2'b01 : (op == 4'h9) ? 2'b10 : 2'b00;

        instr = w; instr_valid = 1'b1;
        #1 check("ready_idle", {15'b0, instr_ready}, 16'd1);
        @(negedge clk);                              // DECODE
        if (!hold) instr_valid = 1'b0;
        check("decode_busy", {15'b0, busy}, 16'd1);
        check("decode_ready", {15'b0, instr_ready}, 16'd0);
        check("decode_illegal", {15'b0, illegal}, {15'b0, !legal});
        check("decode_ld_reg", {15'b0, ld_reg}, 16'd0);
        if (legal) begin
            check("sr1", {13'b0, sr1}, {13'b0, w[8:6]});
            check("sr2", {13'b0, sr2}, {13'b0, w[2:0]});
            check("dr", {13'b0, dr}, {13'b0, w[11:9]});
            check("aluk", {14'b0, aluk}, {14'b0, exp_aluk});
            check("slice", {10'b0, alu_ir_slice}, (op == 4'h9) ? 16'h0 : {10'b0, w[5:0]});
            @(negedge clk);                          // EXEC
            check("exec_gate", {15'b0, gate_alu}, 16'd1);
            check("exec_ld_reg", {15'b0, ld_reg}, 16'd1);
            check("exec_ld_cc", {15'b0, ld_cc}, 16'd1);
            check("exec_bus", bus, res);
            check("exec_done", {15'b0, done}, 16'd0);
            @(negedge clk);                          // DONE, 3 cycles after accept
            ref_regs[w[11:9]] = res;
            ref_nzp = cc_of(res);
            check("done_pulse", {15'b0, done}, 16'd1);
            check("done_ld_reg", {15'b0, ld_reg}, 16'd0);
            check("result", env_regs[w[11:9]], res);
            check("nzp", {13'b0, nzp}, {13'b0, ref_nzp});
            check("dr_hold", {13'b0, dr}, {13'b0, w[11:9]});
        end
        @(negedge clk);                              // back in IDLE
        check("idle_ready", {15'b0, instr_ready}, 16'd1);
        check("idle_done", {15'b0, done}, 16'd0);
        check("idle_nzp", {13'b0, nzp}, {13'b0, ref_nzp});
        $display("[TB] instr=%h legal=%0d result=%h nzp=%b", w, legal, legal ? res : 16'h0, nzp);
    endtask

    initial begin
        logic [15:0] w;
        rst = 1'b1; instr_valid = 1'b0; instr = 16'h0; pre_we = 1'b0; pre_a = 3'd0; pre_d = 16'h0;
        for (int i = 0; i < 8; i++) begin
            env_regs[i] = 16'h0; ref_regs[i] = 16'h0;
        end
        ref_nzp = 3'b010;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", {15'b0, instr_ready}, 16'd1);
        check("rst_busy", {15'b0, busy}, 16'd0);
        check("rst_nzp", {13'b0, nzp}, 16'd2);
        check("rst_fields", {sr1, sr2, dr, aluk, alu_ir_slice[2:0]}, 16'h0);
        check("rst_strobes", {11'b0, gate_alu, ld_reg, ld_cc, done, illegal}, 16'h0);
        @(negedge clk);

        // Directed operate instructions.
        set_reg(3'd1, 16'd5); set_reg(3'd2, 16'd7);
        run(16'h1642, 1'b0);
        set_reg(3'd0, 16'd1);
        run(16'h103F, 1'b0);
        run(16'h103F, 1'b0);
        run(16'h54A0, 1'b0);
        set_reg(3'd5, 16'h00FF);
        run(16'h997F, 1'b0);
        run(16'h0000, 1'b0);
        run(16'h9940, 1'b0);
        check_regs("illegal_regs");

        // instr_valid held high across back-to-back ADDs.
        run(16'h1642, 1'b1);
        run(16'h1263, 1'b1);
        run(16'h1A7B, 1'b1);
        instr_valid = 1'b0;

        // Randomized mix of legal and illegal words.
        for (int n = 0; n < 40; n++) begin
            set_reg(3'($urandom_range(0, 7)), 16'($urandom));
            case ($urandom_range(0, 4))
                0: w = {4'h1, 12'($urandom)};
                1: w = {4'h5, 12'($urandom)};
                2: w = {4'h9, 6'($urandom), 6'h3F};
                3: w = {4'h9, 6'($urandom), 6'($urandom_range(0, 62))};
                default: w = 16'($urandom);
            endcase
            run(w, 1'b0);
        end
        check_regs("random_regs");

        // Reset during EXEC drops the instruction.
        set_reg(3'd1, 16'hFFF0); set_reg(3'd2, 16'h0001);
        run(16'h1642, 1'b0);                         // leaves nzp=100
        set_reg(3'd1, 16'd5); set_reg(3'd2, 16'd7);
        instr = 16'h1642; instr_valid = 1'b1;
        @(negedge clk); instr_valid = 1'b0;          // DECODE
        @(negedge clk);                              // EXEC
        check("rstx_gate", {15'b0, gate_alu}, 16'd1);
        rst = 1'b1;
        #1 check("rstx_ld_reg", {15'b0, ld_reg}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        ref_nzp = 3'b010;
        #1;
        check("rstx_busy", {15'b0, busy}, 16'd0);
        check("rstx_ready", {15'b0, instr_ready}, 16'd1);
        check("rstx_nzp", {13'b0, nzp}, 16'd2);
        check("rstx_fields", {sr1, sr2, dr, aluk, alu_ir_slice[2:0]}, 16'h0);
        check("rstx_slice", {10'b0, alu_ir_slice}, 16'h0);
        check("rstx_strobes", {11'b0, gate_alu, ld_reg, ld_cc, done, illegal}, 16'h0);
        @(negedge clk);
        check("rstx_no_done", {15'b0, done}, 16'd0);
        check_regs("rstx_regs");
        $display("[TB] reset during EXEC of 1642: busy=%0d nzp=%b", busy, nzp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
